// File: rtl/keypad_emulator.sv
// 4x4 matrix keypad responder with LFSR-driven contact bounce.
// Returns row sense R for the latched key from the scanner's column drive C.
// The release command port is named release_cmd because "release" is a reserved word.
module keypad_emulator #(
  parameter logic [23:0] BOUNCE_CYCLES = 24'd150000,
  parameter logic [15:0] TOGGLE_PERIOD = 16'd1000,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       press,
  input  logic       release_cmd,
  input  logic [3:0] key_idx,
  input  logic [3:0] C,
  output logic [3:0] R,
  output logic       contact,
  output logic       held,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    BOUNCE_PRESS   = 2'd1,
    HELD           = 2'd2,
    BOUNCE_RELEASE = 2'd3
  } state_t;

  localparam logic NO_BOUNCE = (BOUNCE_CYCLES == 24'd0);

  state_t      state, state_next;
  logic        contact_next;
  logic [3:0]  key, key_next;
  logic [23:0] bounce_cnt, bounce_next;
  logic [15:0] toggle_cnt, toggle_next;
  logic [7:0]  lfsr, lfsr_next;

  logic [15:0] toggle_inc;
  logic        toggle_hit;
  logic        bounce_last;
  logic [7:0]  lfsr_step;

  // x^8+x^6+x^5+x^4+1, shifted left with feedback into bit 0.
  assign lfsr_step   = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign toggle_inc  = toggle_cnt + 16'd1;
  assign toggle_hit  = (toggle_inc == TOGGLE_PERIOD);
  assign bounce_last = (bounce_cnt == BOUNCE_CYCLES - 24'd1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      contact    <= 1'b0;
      key        <= '0;
      bounce_cnt <= '0;
      toggle_cnt <= '0;
      lfsr       <= LFSR_SEED;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_next;
      contact    <= contact_next;
      key        <= key_next;
      bounce_cnt <= bounce_next;
      toggle_cnt <= toggle_next;
      lfsr       <= lfsr_next;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    state_next   = state;
    contact_next = contact;
    key_next     = key;
    bounce_next  = bounce_cnt;
    toggle_next  = toggle_cnt;
    lfsr_next    = lfsr;

    case (state)
      IDLE: begin
        if (press) begin
          key_next     = key_idx;
          contact_next = 1'b1;
          bounce_next  = '0;
          toggle_next  = '0;
          if (NO_BOUNCE) state_next = HELD;
          else           state_next = BOUNCE_PRESS;
        end
      end

      HELD: begin
        if (release_cmd) begin
          contact_next = 1'b0;
          bounce_next  = '0;
          toggle_next  = '0;
          if (NO_BOUNCE) state_next = IDLE;
          else           state_next = BOUNCE_RELEASE;
        end
      end

      BOUNCE_PRESS, BOUNCE_RELEASE: begin
        if (toggle_hit) begin
          toggle_next = '0;
          lfsr_next   = lfsr_step;
          if (lfsr_step[0]) contact_next = ~contact;
        end else begin
          toggle_next = toggle_inc;
        end
        // The settled contact level overrides any toggle on the final cycle.
        if (bounce_last) begin
          if (state == BOUNCE_PRESS) begin
            state_next   = HELD;
            contact_next = 1'b1;
          end else begin
            state_next   = IDLE;
            contact_next = 1'b0;
          end
        end else begin
          bounce_next = bounce_cnt + 24'd1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    R         = '0;
    R[key[3:2]] = contact & C[key[1:0]];
  end

  assign held = (state == HELD);
  assign busy = (state == BOUNCE_PRESS) || (state == BOUNCE_RELEASE);

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: one no-bounce instance and one
// bouncing instance (20 cycles, toggle period 4, seed A5) checked against a scoreboard.
module tb_keypad_emulator;

  localparam int         BN   = 20;
  localparam int         TP   = 4;
  localparam logic [7:0] SEED = 8'hA5;

  typedef struct packed {
    logic       busy;
    logic       held;
    logic       contact;
    logic [3:0] r;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;

  logic       p0 = 1'b0, rl0 = 1'b0;
  logic [3:0] k0 = '0, c0 = '0;
  logic [3:0] r0;
  logic       contact0, held0, busy0;

  logic       p1 = 1'b0, rl1 = 1'b0;
  logic [3:0] k1 = '0, c1 = '0;
  logic [3:0] r1;
  logic       contact1, held1, busy1;

  int checks = 0;
  int errors = 0;

  obs_t       exp_q[$];
  logic [3:0] r_q[$];
  logic [7:0] model_lfsr;

  keypad_emulator #(
    .BOUNCE_CYCLES(24'd0), .TOGGLE_PERIOD(16'd4), .LFSR_SEED(SEED)
  ) dut0 (
    .clk(clk), .reset(reset), .press(p0), .release_cmd(rl0), .key_idx(k0),
    .C(c0), .R(r0), .contact(contact0), .held(held0), .busy(busy0)
  );

  keypad_emulator #(
    .BOUNCE_CYCLES(24'd20), .TOGGLE_PERIOD(16'd4), .LFSR_SEED(SEED)
  ) dut1 (
    .clk(clk), .reset(reset), .press(p1), .release_cmd(rl1), .key_idx(k1),
    .C(c1), .R(r1), .contact(contact1), .held(held1), .busy(busy1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Expected per-cycle observations of dut1 from the cycle after an accepted press
  // through the first HELD cycle, with C driven all-ones.
  task automatic push_press_seq(input logic [3:0] key);
    logic       c;
    logic [7:0] l;
    int         tc;
    logic [3:0] rowhot;
    rowhot = 4'b0001 << key[3:2];
    c  = 1'b1;
    l  = model_lfsr;
    tc = 0;
    for (int k = 0; k < BN; k++) begin
      exp_q.push_back({1'b1, 1'b0, c, (c ? rowhot : 4'b0000)});
      if (tc + 1 == TP) begin
        tc = 0;
        l  = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        if (l[0]) c = ~c;
      end else begin
        tc++;
      end
    end
    exp_q.push_back({1'b0, 1'b1, 1'b1, rowhot});
    model_lfsr = l;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_lfsr = SEED;
  endtask

  task automatic test_reset();
    c0 = 4'hF;
    c1 = 4'hF;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({busy0, held0, contact0, r0} !== 7'b0) begin
      errors++;
      $display("FAIL reset_dut0: got %b expected 0000000", {busy0, held0, contact0, r0});
    end
    checks++;
    if ({busy1, held1, contact1, r1} !== 7'b0) begin
      errors++;
      $display("FAIL reset_dut1: got %b expected 0000000", {busy1, held1, contact1, r1});
    end
    reset = 1'b1;
    model_lfsr = SEED;
  endtask

  task automatic test_bounce_timing();
    obs_t e, o;
    c1 = 4'hF;
    push_press_seq(4'd5);
    @(negedge clk);
    p1 = 1'b1;
    k1 = 4'd5;
    @(negedge clk);
    p1 = 1'b0;
    for (int i = 1; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = {busy1, held1, contact1, r1};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL bounce_press_t+%0d: got busy/held/contact/R %b expected %b", i, o, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_bounce();
    obs_t e, o;
    apply_reset();
    c1 = 4'hF;
    @(negedge clk);
    p1 = 1'b1;
    k1 = 4'd5;
    @(negedge clk);
    p1 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy1 !== 1'b1) begin
      errors++;
      $display("FAIL mid_bounce_busy: got %b expected 1", busy1);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy1, held1, contact1, r1} !== 7'b0) begin
      errors++;
      $display("FAIL reset_mid_bounce: got %b expected 0000000", {busy1, held1, contact1, r1});
    end
    reset = 1'b1;
    model_lfsr = SEED;
    push_press_seq(4'd5);
    @(negedge clk);
    p1 = 1'b1;
    @(negedge clk);
    p1 = 1'b0;
    for (int i = 1; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = {busy1, held1, contact1, r1};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL after_reset_t+%0d: got busy/held/contact/R %b expected %b", i, o, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_release();
    logic [3:0] e;
    @(negedge clk);
    rl1 = 1'b1;
    @(negedge clk);
    rl1 = 1'b0;
    checks++;
    if ({busy1, held1, contact1} !== 3'b100) begin
      errors++;
      $display("FAIL release_t+1: got busy/held/contact %b expected 100", {busy1, held1, contact1});
    end
    for (int i = 1; i <= BN; i++) begin
      checks++;
      if ({busy1, held1} !== 2'b10) begin
        errors++;
        $display("FAIL release_busy_t+%0d: got busy/held %b expected 10", i, {busy1, held1});
      end
      @(negedge clk);
    end
    checks++;
    if ({busy1, held1, contact1} !== 3'b000) begin
      errors++;
      $display("FAIL release_idle: got busy/held/contact %b expected 000", {busy1, held1, contact1});
    end
    for (int c = 0; c < 16; c++) begin
      c1 = 4'(c);
      r_q.push_back(4'b0000);
      #1;
      e = r_q.pop_front();
      checks++;
      if (r1 !== e) begin
        errors++;
        $display("FAIL release_r_c%0d: got %b expected %b", c, r1, e);
      end
    end
  endtask

  task automatic test_command_filtering();
    logic [3:0] e;
    logic       done;
    c1 = 4'hF;
    @(negedge clk);
    rl1 = 1'b1;
    @(negedge clk);
    rl1 = 1'b0;
    checks++;
    if ({busy1, held1, contact1} !== 3'b000) begin
      errors++;
      $display("FAIL release_in_idle: got %b expected 000", {busy1, held1, contact1});
    end
    p1  = 1'b1;
    rl1 = 1'b1;
    k1  = 4'd5;
    @(negedge clk);
    p1  = 1'b0;
    rl1 = 1'b0;
    checks++;
    if ({busy1, contact1} !== 2'b11) begin
      errors++;
      $display("FAIL press_and_release: got busy/contact %b expected 11", {busy1, contact1});
    end
    p1 = 1'b1;
    k1 = 4'd10;
    @(negedge clk);
    p1 = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (held1 === 1'b1) done = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL filter_settle: held never rose, got %b expected 1", held1);
    end
    for (int i = 0; i < 3; i++) begin
      c1 = (i == 0) ? 4'b1111 : (i == 1) ? 4'b0010 : 4'b0100;
      r_q.push_back((i == 2) ? 4'b0000 : 4'b0010);
      #1;
      e = r_q.pop_front();
      checks++;
      if (r1 !== e) begin
        errors++;
        $display("FAIL latched_key_c%b: got %b expected %b", c1, r1, e);
      end
    end
    @(negedge clk);
    rl1 = 1'b1;
    @(negedge clk);
    rl1 = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (busy1 === 1'b0) done = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!done || held1 !== 1'b0) begin
      errors++;
      $display("FAIL filter_release: got busy/held %b expected 00", {busy1, held1});
    end
  endtask

  task automatic test_decode_no_bounce();
    logic [3:0] e;
    @(negedge clk);
    p0 = 1'b1;
    k0 = 4'b0110;
    @(negedge clk);
    p0 = 1'b0;
    checks++;
    if ({held0, busy0, contact0} !== 3'b101) begin
      errors++;
      $display("FAIL nobounce_held: got held/busy/contact %b expected 101", {held0, busy0, contact0});
    end
    for (int i = 0; i < 3; i++) begin
      c0 = (i == 0) ? 4'b0100 : (i == 1) ? 4'b1000 : 4'b0110;
      r_q.push_back((i == 1) ? 4'b0000 : 4'b0010);
      #1;
      e = r_q.pop_front();
      checks++;
      if (r0 !== e) begin
        errors++;
        $display("FAIL decode_c%b: got %b expected %b", c0, r0, e);
      end
    end
    @(negedge clk);
    rl0 = 1'b1;
    @(negedge clk);
    rl0 = 1'b0;
    checks++;
    if ({held0, busy0, contact0} !== 3'b000) begin
      errors++;
      $display("FAIL nobounce_release: got %b expected 000", {held0, busy0, contact0});
    end
  endtask

  task automatic test_all_keys();
    logic [3:0] e;
    logic [3:0] key;
    for (int k = 0; k < 16; k++) begin
      key = 4'(k);
      @(negedge clk);
      p0 = 1'b1;
      k0 = key;
      @(negedge clk);
      p0 = 1'b0;
      checks++;
      if (held0 !== 1'b1) begin
        errors++;
        $display("FAIL key%0d_held: got %b expected 1", k, held0);
      end
      for (int c = 0; c < 4; c++) begin
        c0 = 4'b0001 << c;
        r_q.push_back((2'(c) == key[1:0]) ? (4'b0001 << key[3:2]) : 4'b0000);
        #1;
        e = r_q.pop_front();
        checks++;
        if (r0 !== e) begin
          errors++;
          $display("FAIL key%0d_col%0d: got %b expected %b", k, c, r0, e);
        end
      end
      @(negedge clk);
      rl0 = 1'b1;
      @(negedge clk);
      rl0 = 1'b0;
      c0 = 4'hF;
      #1;
      checks++;
      if ({held0, r0} !== 5'b0) begin
        errors++;
        $display("FAIL key%0d_release: got held/R %b expected 00000", k, {held0, r0});
      end
    end
  endtask

  initial begin
    test_reset();
    test_bounce_timing();
    test_reset_mid_bounce();
    test_release();
    test_command_filtering();
    test_decode_no_bounce();
    test_all_keys();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
